// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory-access pipeline stage of the LoongArch CPU. Holds one
//            instruction from execute, waits for the data-SRAM response of a
//            load/store, aligns and extends load data, and hands the result
//            plus the exception bundle to write-back. Responses belonging to
//            instructions killed by a write-back flush are counted and dropped.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            EX_to_MEM, EX_to_MEM_zip  - instruction offered by execute
//            EX_except_zip             - exception bundle from execute
//            MEM_allowin               - stage can accept an instruction
//            data_sram_data_ok/_rdata  - data-SRAM response (in order)
//            WB_allowin, flush         - write-back ready / pipeline flush
//            MEM_to_WB, MEM_to_WB_zip  - payload transfer to write-back
//            MEM_except_zip            - registered exception bundle
//            MEM_fwd_*                 - forwarding info for the decode stage
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic         EX_to_MEM,
  input  logic [191:0] EX_to_MEM_zip,
  input  logic [46:0]  EX_except_zip,
  output logic         MEM_allowin,
  input  logic         data_sram_data_ok,
  input  logic [31:0]  data_sram_rdata,
  input  logic         WB_allowin,
  input  logic         flush,
  output logic         MEM_to_WB,
  output logic [186:0] MEM_to_WB_zip,
  output logic [46:0]  MEM_except_zip,
  output logic         MEM_fwd_we,
  output logic [4:0]   MEM_fwd_waddr,
  output logic [31:0]  MEM_fwd_wdata,
  output logic         MEM_fwd_block
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } state_t;

  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_B  = 3'd1;
  localparam logic [2:0] LD_BU = 3'd2;
  localparam logic [2:0] LD_H  = 3'd3;
  localparam logic [2:0] LD_HU = 3'd4;

  // Registered state
  state_t      r_state;
  logic        r_valid;
  logic [1:0]  r_discard_cnt;
  logic [63:0] r_pc_ir;          // {pc, IR}
  logic        r_gr_we;
  logic [4:0]  r_waddr;
  logic [31:0] r_alu;
  logic        r_res_from_mem;
  logic [2:0]  r_ld_type;
  logic [83:0] r_tail;           // {tlb flags[4], csr_re, csr_we, wmask, wvalue, num}
  logic [46:0] r_except;
  logic [31:0] r_rdata;

  // Handshake logic
  logic        w_resp_take;
  logic        w_ready;
  logic        w_allowin;
  logic        w_accept;
  logic        w_to_wb;
  logic        w_in_mem_req;
  logic        w_disc_inc;
  logic        w_disc_dec;

  // A response is consumed only when no stale responses are still owed.
  assign w_resp_take  = data_sram_data_ok & (r_discard_cnt == 2'd0);
  assign w_ready      = (r_state == S_READY) | ((r_state == S_WAIT) & w_resp_take);
  assign w_allowin    = ~r_valid | (w_ready & WB_allowin);
  assign w_accept     = EX_to_MEM & w_allowin;
  assign w_to_wb      = r_valid & w_ready & WB_allowin & ~flush;
  assign w_in_mem_req = EX_to_MEM_zip[84];

  // A flush orphans the outstanding request of the instruction in WAIT
  // (unless its response is arriving right now) or of one entering this cycle.
  assign w_disc_inc = flush & (((r_state == S_WAIT) & ~w_resp_take) |
                               (w_accept & w_in_mem_req));
  assign w_disc_dec = data_sram_data_ok & (r_discard_cnt != 2'd0);

  // The valid bit of the incoming bundle is redundant with EX_to_MEM.
  logic w_unused_in_valid;
  assign w_unused_in_valid = EX_to_MEM_zip[191];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_EMPTY;
      r_valid        <= 1'b0;
      r_discard_cnt  <= 2'd0;
      r_pc_ir        <= '0;
      r_gr_we        <= 1'b0;
      r_waddr        <= '0;
      r_alu          <= '0;
      r_res_from_mem <= 1'b0;
      r_ld_type      <= '0;
      r_tail         <= '0;
      r_except       <= '0;
      r_rdata        <= '0;
    end else begin
      if (w_accept) begin
        r_pc_ir        <= EX_to_MEM_zip[190:127];
        r_gr_we        <= EX_to_MEM_zip[126];
        r_waddr        <= EX_to_MEM_zip[125:121];
        r_alu          <= EX_to_MEM_zip[120:89];
        r_res_from_mem <= EX_to_MEM_zip[88];
        r_ld_type      <= EX_to_MEM_zip[87:85];
        r_tail         <= EX_to_MEM_zip[83:0];
        r_except       <= EX_except_zip;
      end

      // Latch the response once; later data_ok pulses in READY are ignored,
      // so a stalled result survives until write-back takes it.
      if ((r_state == S_WAIT) & w_resp_take) begin
        r_rdata <= data_sram_rdata;
      end

      if (flush) begin
        r_valid <= 1'b0;
        r_state <= S_EMPTY;
      end else if (w_accept) begin
        r_valid <= 1'b1;
        r_state <= w_in_mem_req ? S_WAIT : S_READY;
      end else if (w_to_wb) begin
        r_valid <= 1'b0;
        r_state <= S_EMPTY;
      end else if ((r_state == S_WAIT) & w_resp_take) begin
        r_state <= S_READY;
      end

      case ({w_disc_inc, w_disc_dec})
        2'b10: begin
          if (r_discard_cnt != 2'd3) begin
            r_discard_cnt <= r_discard_cnt + 2'd1;
          end
        end
        2'b01: r_discard_cnt <= r_discard_cnt - 2'd1;
        default: r_discard_cnt <= r_discard_cnt;
      endcase
    end
  end

  // Load data: bypass the SRAM bus in the arrival cycle, else the hold reg.
  logic [31:0] w_ld_word;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_aligned;
  logic [31:0] w_rf_wdata;

  assign w_ld_word = (r_state == S_READY) ? r_rdata : data_sram_rdata;

  always_comb begin
    w_ld_byte = w_ld_word[7:0];
    case (r_alu[1:0])
      2'd0: w_ld_byte = w_ld_word[7:0];
      2'd1: w_ld_byte = w_ld_word[15:8];
      2'd2: w_ld_byte = w_ld_word[23:16];
      2'd3: w_ld_byte = w_ld_word[31:24];
      default: w_ld_byte = w_ld_word[7:0];
    endcase
    w_ld_half = r_alu[1] ? w_ld_word[31:16] : w_ld_word[15:0];

    w_ld_aligned = w_ld_word;
    case (r_ld_type)
      LD_W:    w_ld_aligned = w_ld_word;
      LD_B:    w_ld_aligned = {{24{w_ld_byte[7]}}, w_ld_byte};
      LD_BU:   w_ld_aligned = {24'd0, w_ld_byte};
      LD_H:    w_ld_aligned = {{16{w_ld_half[15]}}, w_ld_half};
      LD_HU:   w_ld_aligned = {16'd0, w_ld_half};
      default: w_ld_aligned = w_ld_word;
    endcase
  end

  assign w_rf_wdata = r_res_from_mem ? w_ld_aligned : r_alu;

  assign MEM_allowin    = w_allowin;
  assign MEM_to_WB      = w_to_wb;
  assign MEM_to_WB_zip  = {r_valid, r_pc_ir, r_gr_we, r_waddr, w_rf_wdata, r_tail};
  assign MEM_except_zip = r_except;
  assign MEM_fwd_we     = r_valid & r_gr_we;
  assign MEM_fwd_waddr  = r_waddr;
  assign MEM_fwd_wdata  = w_rf_wdata;
  // CSR reads resolve in write-back, so they block forwarding like a pending load.
  assign MEM_fwd_block  = r_valid & (~w_ready | r_tail[79]);

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Directed self-checking bench for mem_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         EX_to_MEM;
  logic [191:0] EX_to_MEM_zip;
  logic [46:0]  EX_except_zip;
  logic         MEM_allowin;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         WB_allowin;
  logic         flush;
  logic         MEM_to_WB;
  logic [186:0] MEM_to_WB_zip;
  logic [46:0]  MEM_except_zip;
  logic         MEM_fwd_we;
  logic [4:0]   MEM_fwd_waddr;
  logic [31:0]  MEM_fwd_wdata;
  logic         MEM_fwd_block;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .rst               (rst),
    .EX_to_MEM         (EX_to_MEM),
    .EX_to_MEM_zip     (EX_to_MEM_zip),
    .EX_except_zip     (EX_except_zip),
    .MEM_allowin       (MEM_allowin),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .WB_allowin        (WB_allowin),
    .flush             (flush),
    .MEM_to_WB         (MEM_to_WB),
    .MEM_to_WB_zip     (MEM_to_WB_zip),
    .MEM_except_zip    (MEM_except_zip),
    .MEM_fwd_we        (MEM_fwd_we),
    .MEM_fwd_waddr     (MEM_fwd_waddr),
    .MEM_fwd_wdata     (MEM_fwd_wdata),
    .MEM_fwd_block     (MEM_fwd_block)
  );

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  function automatic logic [191:0] mk(input logic [31:0] alu, input logic [4:0] waddr,
                                      input logic rfm, input logic [2:0] ldt,
                                      input logic mreq, input logic csr_re);
    mk = {1'b1, 32'h1c00_0100, 32'h2880_0000, 1'b1, waddr, alu, rfm, ldt, mreq,
          4'b0000, csr_re, 1'b0, 32'h0, 32'h0, 14'h0};
  endfunction

  // Issue one load, respond after 'delay' wait cycles, check the aligned result.
  task automatic do_load(input string tag, input logic [2:0] ldt, input logic [31:0] alu,
                         input logic [31:0] rdata, input int delay, input logic [31:0] exp);
    EX_to_MEM     = 1'b1;
    EX_to_MEM_zip = mk(alu, 5'd7, 1'b1, ldt, 1'b1, 1'b0);
    tick();
    EX_to_MEM = 1'b0;
    for (int i = 0; i < delay; i++) begin
      settle();
      chk({tag, "_block"}, MEM_fwd_block, 1'b1);
      chk({tag, "_hold"}, MEM_to_WB, 1'b0);
      tick();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rdata;
    settle();
    chk({tag, "_to_wb"}, MEM_to_WB, 1'b1);
    chk({tag, "_wdata"}, MEM_to_WB_zip[115:84], exp);
    chk({tag, "_unblock"}, MEM_fwd_block, 1'b0);
    tick();
    data_sram_data_ok = 1'b0;
  endtask

  initial begin
    rst = 1'b1; EX_to_MEM = 1'b0; EX_to_MEM_zip = '0; EX_except_zip = '0;
    data_sram_data_ok = 1'b0; data_sram_rdata = '0; WB_allowin = 1'b1; flush = 1'b0;
    tick(); tick();
    rst = 1'b0;
    settle();
    chk("rst_allowin", MEM_allowin, 1'b1);
    chk("rst_to_wb", MEM_to_WB, 1'b0);
    chk("rst_zip", MEM_to_WB_zip, 187'd0);
    chk("rst_exc", MEM_except_zip, 47'd0);
    chk("rst_fwd_we", MEM_fwd_we, 1'b0);
    chk("rst_fwd_block", MEM_fwd_block, 1'b0);

    // ALU op
    tick();
    EX_to_MEM = 1'b1;
    EX_to_MEM_zip = mk(32'h1234_5678, 5'd5, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    EX_to_MEM = 1'b0;
    settle();
    chk("alu_to_wb", MEM_to_WB, 1'b1);
    chk("alu_wdata", MEM_to_WB_zip[115:84], 32'h1234_5678);
    chk("alu_valid", MEM_to_WB_zip[186], 1'b1);
    chk("alu_fwd_we", MEM_fwd_we, 1'b1);
    chk("alu_fwd_waddr", MEM_fwd_waddr, 5'd5);
    chk("alu_fwd_wdata", MEM_fwd_wdata, 32'h1234_5678);
    chk("alu_fwd_block", MEM_fwd_block, 1'b0);
    tick();
    settle();
    chk("alu_done", MEM_to_WB, 1'b0);
    chk("alu_allowin", MEM_allowin, 1'b1);
    tick();

    // Alignment
    do_load("ldb",  3'd1, 32'h0000_1002, 32'h0080_0000, 3, 32'hFFFF_FF80);
    do_load("ldbu", 3'd2, 32'h0000_1002, 32'h0080_0000, 3, 32'h0000_0080);
    do_load("ldh",  3'd3, 32'h0000_2002, 32'h8001_0000, 1, 32'hFFFF_8001);
    do_load("ldhu", 3'd4, 32'h0000_2002, 32'h8001_0000, 1, 32'h0000_8001);
    do_load("ldw",  3'd0, 32'h0000_3000, 32'hA5A5_0F0F, 0, 32'hA5A5_0F0F);

    // Flush while a load waits: its response must be dropped
    EX_to_MEM = 1'b1;
    EX_to_MEM_zip = mk(32'h2000, 5'd9, 1'b1, 3'd0, 1'b1, 1'b0);
    tick();
    EX_to_MEM = 1'b0;
    flush = 1'b1;
    settle();
    chk("fl_to_wb", MEM_to_WB, 1'b0);
    tick();
    flush = 1'b0;
    settle();
    chk("fl_allowin", MEM_allowin, 1'b1);
    chk("fl_fwd_we", MEM_fwd_we, 1'b0);
    EX_to_MEM = 1'b1;
    EX_to_MEM_zip = mk(32'h3000, 5'd10, 1'b1, 3'd0, 1'b1, 1'b0);
    tick();
    EX_to_MEM = 1'b0;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_DEAD;
    settle();
    chk("fl_stale_drop", MEM_to_WB, 1'b0);
    chk("fl_stale_block", MEM_fwd_block, 1'b1);
    tick();
    data_sram_rdata = 32'h0000_BEEF;
    settle();
    chk("fl_new_to_wb", MEM_to_WB, 1'b1);
    chk("fl_new_wdata", MEM_to_WB_zip[115:84], 32'h0000_BEEF);
    tick();
    data_sram_data_ok = 1'b0;
    do_load("fl_cnt0", 3'd0, 32'h4000, 32'h0000_0055, 0, 32'h0000_0055);

    // Response during a write-back stall
    EX_to_MEM = 1'b1;
    EX_to_MEM_zip = mk(32'h5000, 5'd11, 1'b1, 3'd0, 1'b1, 1'b0);
    tick();
    EX_to_MEM = 1'b0;
    WB_allowin = 1'b0;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFE_F00D;
    settle();
    chk("st_to_wb", MEM_to_WB, 1'b0);
    chk("st_allowin", MEM_allowin, 1'b0);
    tick();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h1111_1111;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("st_hold_allowin", MEM_allowin, 1'b0);
      chk("st_hold_wdata", MEM_fwd_wdata, 32'hCAFE_F00D);
      tick();
    end
    WB_allowin = 1'b1;
    settle();
    chk("st_rel_to_wb", MEM_to_WB, 1'b1);
    chk("st_rel_wdata", MEM_to_WB_zip[115:84], 32'hCAFE_F00D);
    tick();

    // Back-to-back loads with immediate responses
    EX_to_MEM = 1'b1;
    EX_to_MEM_zip = mk(32'h6000, 5'd12, 1'b1, 3'd0, 1'b1, 1'b0);
    tick();
    EX_to_MEM_zip = mk(32'h6004, 5'd13, 1'b1, 3'd0, 1'b1, 1'b0);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_000A;
    settle();
    chk("b2b_a_to_wb", MEM_to_WB, 1'b1);
    chk("b2b_a_wdata", MEM_to_WB_zip[115:84], 32'h0000_000A);
    chk("b2b_allowin", MEM_allowin, 1'b1);
    tick();
    EX_to_MEM = 1'b0;
    data_sram_rdata = 32'h0000_000B;
    settle();
    chk("b2b_b_to_wb", MEM_to_WB, 1'b1);
    chk("b2b_b_waddr", MEM_fwd_waddr, 5'd13);
    chk("b2b_b_wdata", MEM_to_WB_zip[115:84], 32'h0000_000B);
    tick();
    data_sram_data_ok = 1'b0;

    // Exception pass-through (ale flag + vaddr)
    EX_to_MEM = 1'b1;
    EX_to_MEM_zip = mk(32'h1003, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    EX_except_zip = {1'b0, 14'b00_0000_0010_0000, 32'h0000_1003};
    tick();
    EX_to_MEM = 1'b0;
    settle();
    chk("exc_zip", MEM_except_zip, {1'b0, 14'b00_0000_0010_0000, 32'h0000_1003});
    chk("exc_to_wb", MEM_to_WB, 1'b1);
    tick();

    // Reset mid-WAIT with a stale response still owed
    EX_to_MEM = 1'b1;
    EX_to_MEM_zip = mk(32'h7000, 5'd14, 1'b1, 3'd0, 1'b1, 1'b0);
    tick();
    EX_to_MEM = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    EX_to_MEM = 1'b1;
    EX_to_MEM_zip = mk(32'h7004, 5'd15, 1'b1, 3'd0, 1'b1, 1'b1);
    tick();
    EX_to_MEM = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    EX_except_zip = '0;
    settle();
    chk("mrst_allowin", MEM_allowin, 1'b1);
    chk("mrst_to_wb", MEM_to_WB, 1'b0);
    chk("mrst_zip", MEM_to_WB_zip, 187'd0);
    chk("mrst_exc", MEM_except_zip, 47'd0);
    chk("mrst_fwd_we", MEM_fwd_we, 1'b0);
    chk("mrst_fwd_block", MEM_fwd_block, 1'b0);
    tick();
    do_load("mrst_cnt0", 3'd0, 32'h8000, 32'h0000_0077, 0, 32'h0000_0077);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
